// File: rtl/pixaddr_to_pos.sv
// pixaddr_to_pos: converts a pixel memory address back into an (x, y)
// screen position using a multi-cycle restoring shift-subtract divider.
// Bit 18 selects the row width: 640 for the encrypted image, 320 for the
// decrypted one. Bits 17:0 hold the offset row*width + col.
module pixaddr_to_pos #(
  parameter int W_ENC = 640,
  parameter int W_DEC = 320,
  parameter int QBITS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      pix_addr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [9:0]       pos_x,
  output logic [QBITS-1:0] pos_y,
  output logic             img_sel,
  output logic             addr_err
);

  localparam int IW = (QBITS > 1) ? $clog2(QBITS) : 1;
  localparam int DW = 18 + QBITS;  // wide enough that div << iter never truncates

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t           r_state, w_next;
  logic [17:0]      r_rem;
  logic [9:0]       r_div;
  logic [QBITS-1:0] r_q;
  logic [IW-1:0]    r_iter;
  logic             r_img_sel;
  logic             r_addr_err;

  logic [DW-1:0]    w_dsh;
  logic             w_ge;
  logic [17:0]      w_sub;

  // Shifted divisor and trial subtraction for the current quotient bit.
  // When w_ge holds, w_dsh <= rem < 2^18, so the low 18 bits are exact.
  assign w_dsh = DW'(r_div) << r_iter;
  assign w_ge  = DW'(r_rem) >= w_dsh;
  assign w_sub = r_rem - w_dsh[17:0];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic: one accept cycle, QBITS divide cycles, then hold until taken.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (in_valid)         w_next = DIV;
      DIV:  if (r_iter == '0)     w_next = DONE;
      DONE: if (out_ready)        w_next = IDLE;
      default:                    w_next = IDLE;
    endcase
  end

  // Datapath: latch the request on accept, then one quotient bit per cycle, MSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem      <= '0;
      r_div      <= '0;
      r_q        <= '0;
      r_iter     <= '0;
      r_img_sel  <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_rem      <= pix_addr[17:0];
          r_div      <= pix_addr[18] ? 10'(W_DEC) : 10'(W_ENC);
          r_img_sel  <= pix_addr[18];
          r_addr_err <= |pix_addr[31:19];
          r_iter     <= IW'(QBITS - 1);
        end
        DIV: begin
          if (w_ge) r_rem <= w_sub;
          r_q    <= {r_q[QBITS-2:0], w_ge};
          r_iter <= r_iter - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign pos_x     = r_rem[9:0];
  assign pos_y     = r_q;
  assign img_sel   = r_img_sel;
  assign addr_err  = r_addr_err;

endmodule

// File: tb/tb_pixaddr_to_pos.sv
// Directed bench for pixaddr_to_pos: known addresses with hand-computed positions,
// latency, boundaries, back-pressure and mid-conversion reset.
module tb_pixaddr_to_pos;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] pix_addr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [9:0]  pos_x;
  logic [9:0]  pos_y;
  logic        img_sel;
  logic        addr_err;

  int n_tot = 0;
  int n_bad = 0;

  pixaddr_to_pos dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .pix_addr(pix_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .pos_x(pos_x), .pos_y(pos_y), .img_sel(img_sel), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Present one address, wait for the result, check it, then take it.
  task automatic conv(input string tag, input logic [31:0] a, input int ex, input int ey,
                      input logic es, input logic ee);
    int n;
    @(negedge clk);
    chk({tag, "_rdy"}, in_ready, 1);
    in_valid = 1'b1;
    pix_addr = a;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, 10);
    chk({tag, "_x"}, pos_x, ex);
    chk({tag, "_y"}, pos_y, ey);
    chk({tag, "_sel"}, img_sel, es);
    chk({tag, "_err"}, addr_err, ee);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_ovld0"}, out_valid, 0);
    chk({tag, "_irdy1"}, in_ready, 1);
  endtask

  initial begin
    int n;
    // reset state
    #12;
    chk("rst_irdy", in_ready, 1);
    chk("rst_ovld", out_valid, 0);
    chk("rst_x", pos_x, 0);
    chk("rst_y", pos_y, 0);
    chk("rst_sel", img_sel, 0);
    chk("rst_err", addr_err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    conv("dec1000", 32'h0004_03E8,  40,   3, 1'b1, 1'b0);
    conv("enc_max", 32'h0003_FFFF, 383, 409, 1'b0, 1'b0);
    conv("dec_max", 32'h0007_FFFF,  63, 819, 1'b1, 1'b0);
    conv("enc639",  32'h0000_027F, 639,   0, 1'b0, 1'b0);
    conv("enc640",  32'h0000_0280,   0,   1, 1'b0, 1'b0);
    conv("enc0",    32'h0000_0000,   0,   0, 1'b0, 1'b0);
    conv("err",     32'h0008_0280,   0,   1, 1'b0, 1'b1);
    conv("dec319",  32'h0004_013F, 319,   0, 1'b1, 1'b0);

    // back-pressure: 1000/320 = (40,3); a competing request must be ignored
    @(negedge clk);
    in_valid = 1'b1;
    pix_addr = 32'h0004_03E8;
    @(posedge clk); #1;
    pix_addr = 32'h0000_027F;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_lat", n, 10);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("bp_ovld", out_valid, 1);
      chk("bp_irdy", in_ready, 0);
      chk("bp_x", pos_x, 40);
      chk("bp_y", pos_y, 3);
      chk("bp_sel", img_sel, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_ovld0", out_valid, 0);
    chk("bp_irdy1", in_ready, 1);

    // reset in the middle of the divide
    @(negedge clk);
    in_valid = 1'b1;
    pix_addr = 32'h0003_FFFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_ovld", out_valid, 0);
    chk("mrst_irdy", in_ready, 1);
    chk("mrst_x", pos_x, 0);
    chk("mrst_y", pos_y, 0);
    @(negedge clk);
    rst_n = 1'b1;
    conv("post_rst", 32'h0004_03E8, 40, 3, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
